// File: rtl/cic_decimator_n_if.sv
// Sample-stream interface for cic_decimator_n: input samples with qualifier,
// runtime ratio/shift controls, and decimated output strobe/data.
interface cic_decimator_n_if #(
    parameter int DATA_WIDTH     = 12,
    parameter int OUT_WIDTH      = 16,
    parameter int STAGES         = 5,
    parameter int MAX_DECIMATION = 64,
    parameter int DIFF_DELAY     = 1
);
    localparam int REG_WIDTH   = DATA_WIDTH + STAGES * $clog2(MAX_DECIMATION * DIFF_DELAY);
    localparam int RATIO_WIDTH = $clog2(MAX_DECIMATION + 1);
    localparam int SHIFT_WIDTH = $clog2(REG_WIDTH);

    logic                          in_valid;
    logic signed [DATA_WIDTH-1:0]  data_in;
    logic        [RATIO_WIDTH-1:0] dec_ratio;
    logic        [SHIFT_WIDTH-1:0] shift;
    logic                          out_valid;
    logic signed [OUT_WIDTH-1:0]   data_out;

    modport master (output in_valid, data_in, dec_ratio, shift, input out_valid, data_out);
    modport slave  (input in_valid, data_in, dec_ratio, shift, output out_valid, data_out);
endinterface

// File: rtl/cic_decimator_n.sv
// N-stage CIC decimator with runtime ratio, differential delay M, programmable shift and
// saturating registered output. Define CIC_ROUND_EN for round-half-up ahead of the shift.
module cic_decimator_n #(
    parameter int DATA_WIDTH     = 12,
    parameter int OUT_WIDTH      = 16,
    parameter int STAGES         = 5,
    parameter int MAX_DECIMATION = 64,
    parameter int DIFF_DELAY     = 1
) (
    input  logic             clk,
    input  logic             arst,
    cic_decimator_n_if.slave bus
);
    localparam int REG_WIDTH   = DATA_WIDTH + STAGES * $clog2(MAX_DECIMATION * DIFF_DELAY);
    localparam int RATIO_WIDTH = $clog2(MAX_DECIMATION + 1);
    localparam int SHIFT_WIDTH = $clog2(REG_WIDTH);
    localparam int ACC_WIDTH   = REG_WIDTH + 1;

    typedef logic signed [REG_WIDTH-1:0] reg_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;

    localparam reg_t REG_ZERO = {REG_WIDTH{1'b0}};
    localparam acc_t ACC_ZERO = {ACC_WIDTH{1'b0}};
    localparam acc_t SAT_MAX  = {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam acc_t SAT_MIN  = {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    function automatic logic signed [OUT_WIDTH-1:0] saturate(input acc_t v);
        if (v > SAT_MAX) begin
            saturate = SAT_MAX[OUT_WIDTH-1:0];
        end else if (v < SAT_MIN) begin
            saturate = SAT_MIN[OUT_WIDTH-1:0];
        end else begin
            saturate = v[OUT_WIDTH-1:0];
        end
    endfunction

    logic [RATIO_WIDTH-1:0]      cnt_q, cnt_d, r_act_q, r_act_d, r_req_s, r_use_s;
    logic                        event_s;
    reg_t                        integ_q [STAGES];
    reg_t                        integ_d [STAGES];
    reg_t                        cap_q;
    logic                        cap_v_q;
    reg_t                        comb_q   [STAGES];
    reg_t                        comb_x_s [STAGES];
    logic [STAGES-1:0]           comb_v_q, comb_vin_s;
    reg_t                        dly_q [STAGES][DIFF_DELAY];
    logic [SHIFT_WIDTH-1:0]      shamt_s;
    acc_t                        pre_s, shr_s, shr_q;
    logic                        shr_v_q;
    logic signed [OUT_WIDTH-1:0] out_q;
    logic                        out_v_q;
`ifdef CIC_ROUND_EN
    localparam acc_t ACC_ONE = {{(ACC_WIDTH-1){1'b0}}, 1'b1};
    acc_t            round_s;
`endif

    // Ratio clamp, period counter and decimation event; a new ratio only lands at count 0
    always_comb begin
        r_req_s = bus.dec_ratio;
        if (bus.dec_ratio <= RATIO_WIDTH'(1)) begin
            r_req_s = RATIO_WIDTH'(1);
        end else if (bus.dec_ratio > RATIO_WIDTH'(MAX_DECIMATION)) begin
            r_req_s = RATIO_WIDTH'(MAX_DECIMATION);
        end else begin
            r_req_s = bus.dec_ratio;
        end
        r_use_s = (cnt_q == RATIO_WIDTH'(0)) ? r_req_s : r_act_q;
        event_s = bus.in_valid && (cnt_q == (r_use_s - RATIO_WIDTH'(1)));
        r_act_d = r_act_q;
        cnt_d   = cnt_q;
        if (bus.in_valid) begin
            r_act_d = r_use_s;
            cnt_d   = event_s ? RATIO_WIDTH'(0) : (cnt_q + RATIO_WIDTH'(1));
        end else begin
            r_act_d = r_act_q;
            cnt_d   = cnt_q;
        end
    end

    // Integrator next values; the capture uses the sum that includes the current sample
    always_comb begin
        integ_d[0] = integ_q[0] + {{(REG_WIDTH-DATA_WIDTH){bus.data_in[DATA_WIDTH-1]}}, bus.data_in};
        for (int k = 1; k < STAGES; k++) begin
            integ_d[k] = integ_q[k] + integ_q[k-1];
        end
    end

    // Integrators, counter and comb input capture
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int k = 0; k < STAGES; k++) integ_q[k] <= REG_ZERO;
            cnt_q   <= RATIO_WIDTH'(0);
            r_act_q <= RATIO_WIDTH'(0);
            cap_q   <= REG_ZERO;
            cap_v_q <= 1'b0;
        end else begin
            if (bus.in_valid) begin
                for (int k = 0; k < STAGES; k++) integ_q[k] <= integ_d[k];
            end
            cnt_q   <= cnt_d;
            r_act_q <= r_act_d;
            cap_v_q <= event_s;
            if (event_s) cap_q <= integ_d[STAGES-1];
        end
    end

    // Comb stage inputs: each stage is fed by its predecessor along with its valid bit
    always_comb begin
        comb_x_s[0]   = cap_q;
        comb_vin_s[0] = cap_v_q;
        for (int k = 1; k < STAGES; k++) begin
            comb_x_s[k]   = comb_q[k-1];
            comb_vin_s[k] = comb_v_q[k-1];
        end
    end

    // Comb pipeline y = x - x[n-M]
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            comb_v_q <= {STAGES{1'b0}};
            for (int k = 0; k < STAGES; k++) begin
                comb_q[k] <= REG_ZERO;
                for (int j = 0; j < DIFF_DELAY; j++) dly_q[k][j] <= REG_ZERO;
            end
        end else begin
            comb_v_q <= comb_vin_s;
            for (int k = 0; k < STAGES; k++) begin
                if (comb_vin_s[k]) begin
                    comb_q[k]   <= comb_x_s[k] - dly_q[k][DIFF_DELAY-1];
                    dly_q[k][0] <= comb_x_s[k];
                    for (int j = 1; j < DIFF_DELAY; j++) dly_q[k][j] <= dly_q[k][j-1];
                end
            end
        end
    end

    // Clamped arithmetic shift; one extra bit keeps the rounding add from wrapping
    always_comb begin
        if (bus.shift > SHIFT_WIDTH'(REG_WIDTH - 1)) begin
            shamt_s = SHIFT_WIDTH'(REG_WIDTH - 1);
        end else begin
            shamt_s = bus.shift;
        end
`ifdef CIC_ROUND_EN
        if (shamt_s != SHIFT_WIDTH'(0)) begin
            round_s = ACC_ONE <<< (shamt_s - SHIFT_WIDTH'(1));
        end else begin
            round_s = ACC_ZERO;
        end
        pre_s = {comb_q[STAGES-1][REG_WIDTH-1], comb_q[STAGES-1]} + round_s;
`else
        pre_s = {comb_q[STAGES-1][REG_WIDTH-1], comb_q[STAGES-1]};
`endif
        shr_s = pre_s >>> shamt_s;
    end

    // Shift and saturation register stages; data_out holds between strobes
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            shr_q   <= ACC_ZERO;
            shr_v_q <= 1'b0;
            out_q   <= {OUT_WIDTH{1'b0}};
            out_v_q <= 1'b0;
        end else begin
            shr_v_q <= comb_v_q[STAGES-1];
            if (comb_v_q[STAGES-1]) shr_q <= shr_s;
            out_v_q <= shr_v_q;
            if (shr_v_q) out_q <= saturate(shr_q);
        end
    end

    assign bus.out_valid = out_v_q;
    assign bus.data_out  = out_q;
endmodule

// File: tb/tb_cic_decimator_n.sv
// Bench for cic_decimator_n: a 3-stage and a 5-stage instance driven in lockstep and
// compared against an arithmetic CIC model kept in the bench.
module tb_cic_decimator_n;
    localparam int DW = 12, OW = 16, MAXD = 64, MD = 1, SA = 3, SB = 5;
    localparam int RWA = DW + SA * $clog2(MAXD * MD);
    localparam int RWB = DW + SB * $clog2(MAXD * MD);
    localparam int RTW = $clog2(MAXD + 1);
    localparam int SWA = $clog2(RWA);
    localparam int SWB = $clog2(RWB);

    logic clk = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    cic_decimator_n_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .STAGES(SA), .MAX_DECIMATION(MAXD), .DIFF_DELAY(MD)) ifa ();
    cic_decimator_n_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .STAGES(SB), .MAX_DECIMATION(MAXD), .DIFF_DELAY(MD)) ifb ();

    cic_decimator_n #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .STAGES(SA), .MAX_DECIMATION(MAXD), .DIFF_DELAY(MD))
        dut_a (.clk(clk), .arst(arst), .bus(ifa));
    cic_decimator_n #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .STAGES(SB), .MAX_DECIMATION(MAXD), .DIFF_DELAY(MD))
        dut_b (.clk(clk), .arst(arst), .bus(ifb));

    int pass_cnt = 0, chk_cnt = 0;
    int cyc = 0;
    int dbl_a = 0;
    bit pva = 1'b0;
    longint obs_da[$], exp_da[$], obs_db[$], exp_db[$], dc_exp[$];
    int     obs_ca[$], exp_ca[$], obs_cb[$], exp_cb[$];

    longint m_int [2][8];
    longint m_cprev [2][8];
    int     m_cnt [2];
    int     m_ract [2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ifa.out_valid) begin
            obs_da.push_back(longint'(ifa.data_out));
            obs_ca.push_back(cyc);
            if (pva) dbl_a <= dbl_a + 1;
        end
        pva <= ifa.out_valid;
        if (ifb.out_valid) begin
            obs_db.push_back(longint'(ifb.data_out));
            obs_cb.push_back(cyc);
        end
    end

    function automatic longint wrapw(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    task automatic model_clear();
        for (int u = 0; u < 2; u++) begin
            m_cnt[u] = 0;
            m_ract[u] = 1;
            for (int k = 0; k < 8; k++) begin
                m_int[u][k] = 0;
                m_cprev[u][k] = 0;
            end
        end
        obs_da.delete(); exp_da.delete(); obs_ca.delete(); exp_ca.delete();
        obs_db.delete(); exp_db.delete(); obs_cb.delete(); exp_cb.delete();
    endtask

    // One accepted sample: integrate, count the period, and on its last sample run the combs.
    task automatic model_step(input int u, input int st, input int rw, input bit v, input longint d,
                              input int r, input int s, output bit ev, output longint y);
        longint x, t;
        int sm;
        ev = 1'b0;
        y = 0;
        if (!v) return;
        for (int k = st - 1; k >= 1; k--) m_int[u][k] = wrapw(m_int[u][k] + m_int[u][k-1], rw);
        m_int[u][0] = wrapw(m_int[u][0] + d, rw);
        if (m_cnt[u] == 0) m_ract[u] = (r <= 1) ? 1 : ((r > MAXD) ? MAXD : r);
        if (m_cnt[u] == m_ract[u] - 1) begin
            x = m_int[u][st-1];
            for (int k = 0; k < st; k++) begin
                t = wrapw(x - m_cprev[u][k], rw);
                m_cprev[u][k] = x;
                x = t;
            end
            sm = (s > rw - 1) ? rw - 1 : s;
`ifdef CIC_ROUND_EN
            if (sm > 0) x = x + (longint'(1) <<< (sm - 1));
`endif
            x = x >>> sm;
            if (x > 32767) x = 32767;
            else if (x < -32768) x = -32768;
            y = x;
            ev = 1'b1;
            m_cnt[u] = 0;
        end else begin
            m_cnt[u] = m_cnt[u] + 1;
        end
    endtask

    task automatic drive(input bit v, input int d, input int r, input int s);
        bit ev;
        longint y;
        int e;
        ifa.in_valid = v; ifa.data_in = DW'(d); ifa.dec_ratio = RTW'(r); ifa.shift = SWA'(s);
        ifb.in_valid = v; ifb.data_in = DW'(d); ifb.dec_ratio = RTW'(r); ifb.shift = SWB'(s);
        e = cyc + 1;
        model_step(0, SA, RWA, v, longint'(d), r, s % (1 << SWA), ev, y);
        if (ev) begin exp_da.push_back(y); exp_ca.push_back(e + SA + 2); end
        model_step(1, SB, RWB, v, longint'(d), r, s % (1 << SWB), ev, y);
        if (ev) begin exp_db.push_back(y); exp_cb.push_back(e + SB + 2); end
        @(negedge clk);
    endtask

    task automatic do_reset();
        arst = 1'b1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        arst = 1'b0;
        model_clear();
        dbl_a = 0;
    endtask

    task automatic test_reset();
        chk_cnt++; if (ifa.out_valid !== 1'b0) $display("FAIL reset_valid_a got %0b want 0", ifa.out_valid); else pass_cnt++;
        chk_cnt++; if (ifa.data_out !== 16'sd0) $display("FAIL reset_data_a got %0d want 0", ifa.data_out); else pass_cnt++;
        chk_cnt++; if (ifb.out_valid !== 1'b0) $display("FAIL reset_valid_b got %0b want 0", ifb.out_valid); else pass_cnt++;
        chk_cnt++; if (ifb.data_out !== 16'sd0) $display("FAIL reset_data_b got %0d want 0", ifb.data_out); else pass_cnt++;
    endtask

    task automatic test_dc();
        do_reset();
        for (int i = 0; i < 40; i++) drive(1, 1, 4, 0);
        for (int i = 0; i < 10; i++) drive(0, 0, 4, 0);
        dc_exp = exp_da;
        chk_cnt++; if (obs_da.size() !== 10) $display("FAIL dc_count got %0d want 10", obs_da.size()); else pass_cnt++;
        for (int i = 0; i < obs_da.size() && i < exp_da.size(); i++) begin
            chk_cnt++; if (obs_da[i] !== exp_da[i]) $display("FAIL dc_data[%0d] got %0d want %0d", i, obs_da[i], exp_da[i]); else pass_cnt++;
            chk_cnt++; if (obs_ca[i] !== exp_ca[i]) $display("FAIL dc_cycle[%0d] got %0d want %0d", i, obs_ca[i], exp_ca[i]); else pass_cnt++;
            if (i >= 3) begin
                chk_cnt++; if (obs_da[i] !== 64) $display("FAIL dc_settle[%0d] got %0d want 64", i, obs_da[i]); else pass_cnt++;
            end
            if (i >= 1) begin
                chk_cnt++; if (obs_ca[i] - obs_ca[i-1] !== 4) $display("FAIL dc_period[%0d] got %0d want 4", i, obs_ca[i] - obs_ca[i-1]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_gaps();
        do_reset();
        for (int i = 0; i < 80; i++) drive(i % 2 == 0, 1, 4, 0);
        for (int i = 0; i < 10; i++) drive(0, 0, 4, 0);
        chk_cnt++; if (obs_da.size() !== dc_exp.size()) $display("FAIL gap_count got %0d want %0d", obs_da.size(), dc_exp.size()); else pass_cnt++;
        chk_cnt++; if (dbl_a !== 0) $display("FAIL gap_wide_strobe got %0d want 0", dbl_a); else pass_cnt++;
        for (int i = 0; i < obs_da.size() && i < dc_exp.size(); i++) begin
            chk_cnt++; if (obs_da[i] !== dc_exp[i]) $display("FAIL gap_data[%0d] got %0d want %0d", i, obs_da[i], dc_exp[i]); else pass_cnt++;
            if (i >= 1) begin
                chk_cnt++; if (obs_ca[i] - obs_ca[i-1] !== 8) $display("FAIL gap_period[%0d] got %0d want 8", i, obs_ca[i] - obs_ca[i-1]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_round();
        longint want;
`ifdef CIC_ROUND_EN
        want = 1;
`else
        want = 0;
`endif
        do_reset();
        for (int i = 0; i < 40; i++) drive(1, 1, 4, 7);
        for (int i = 0; i < 10; i++) drive(0, 0, 4, 7);
        chk_cnt++; if (obs_da.size() !== 10) $display("FAIL round_count got %0d want 10", obs_da.size()); else pass_cnt++;
        if (obs_da.size() > 0) begin
            chk_cnt++; if (obs_da[obs_da.size()-1] !== want) $display("FAIL round_value got %0d want %0d", obs_da[obs_da.size()-1], want); else pass_cnt++;
        end
        for (int i = 0; i < obs_da.size() && i < exp_da.size(); i++) begin
            chk_cnt++; if (obs_da[i] !== exp_da[i]) $display("FAIL round_data[%0d] got %0d want %0d", i, obs_da[i], exp_da[i]); else pass_cnt++;
        end
    endtask

    task automatic test_saturation();
        for (int pol = 0; pol < 2; pol++) begin
            int d;
            longint want;
            d = (pol == 0) ? 2047 : -2048;
            want = (pol == 0) ? 32767 : -32768;
            do_reset();
            for (int i = 0; i < 640; i++) drive(1, d, 64, 0);
            for (int i = 0; i < 12; i++) drive(0, 0, 64, 0);
            chk_cnt++; if (obs_db.size() !== 10) $display("FAIL sat%0d_count got %0d want 10", pol, obs_db.size()); else pass_cnt++;
            if (obs_db.size() > 0) begin
                chk_cnt++; if (obs_db[obs_db.size()-1] !== want) $display("FAIL sat%0d_value got %0d want %0d", pol, obs_db[obs_db.size()-1], want); else pass_cnt++;
            end
            for (int i = 0; i < obs_db.size() && i < exp_db.size(); i++) begin
                chk_cnt++; if (obs_db[i] !== exp_db[i]) $display("FAIL sat%0d_data[%0d] got %0d want %0d", pol, i, obs_db[i], exp_db[i]); else pass_cnt++;
                chk_cnt++; if (obs_cb[i] !== exp_cb[i]) $display("FAIL sat%0d_cycle[%0d] got %0d want %0d", pol, i, obs_cb[i], exp_cb[i]); else pass_cnt++;
            end
        end
    endtask

    task automatic test_ratio_change();
        int e0;
        do_reset();
        e0 = cyc + 1;
        for (int i = 0; i < 2; i++) drive(1, 1, 4, 0);
        for (int i = 0; i < 200; i++) drive(1, 1, 8, 0);
        for (int i = 0; i < 10; i++) drive(0, 0, 8, 0);
        if (obs_da.size() >= 2) begin
            chk_cnt++; if (obs_ca[0] !== e0 + 3 + SA + 2) $display("FAIL ratio_first got %0d want %0d", obs_ca[0], e0 + 3 + SA + 2); else pass_cnt++;
            chk_cnt++; if (obs_ca[1] - obs_ca[0] !== 8) $display("FAIL ratio_second got %0d want 8", obs_ca[1] - obs_ca[0]); else pass_cnt++;
            chk_cnt++; if (obs_da[obs_da.size()-1] !== 512) $display("FAIL ratio_settle got %0d want 512", obs_da[obs_da.size()-1]); else pass_cnt++;
        end else begin
            chk_cnt++; $display("FAIL ratio_outputs got %0d want >=2", obs_da.size());
        end
        chk_cnt++; if (obs_da.size() !== exp_da.size()) $display("FAIL ratio_count got %0d want %0d", obs_da.size(), exp_da.size()); else pass_cnt++;
        for (int i = 0; i < obs_da.size() && i < exp_da.size(); i++) begin
            chk_cnt++; if (obs_da[i] !== exp_da[i]) $display("FAIL ratio_data[%0d] got %0d want %0d", i, obs_da[i], exp_da[i]); else pass_cnt++;
        end
    endtask

    task automatic test_ratio_zero();
        do_reset();
        for (int i = 0; i < 30; i++) drive(1, 1, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0);
        chk_cnt++; if (obs_da.size() !== 30) $display("FAIL r0_count got %0d want 30", obs_da.size()); else pass_cnt++;
        if (obs_da.size() > 1) begin
            chk_cnt++; if (obs_da[obs_da.size()-1] !== 1) $display("FAIL r0_settle got %0d want 1", obs_da[obs_da.size()-1]); else pass_cnt++;
            chk_cnt++; if (obs_ca[1] - obs_ca[0] !== 1) $display("FAIL r0_period got %0d want 1", obs_ca[1] - obs_ca[0]); else pass_cnt++;
        end
        for (int i = 0; i < obs_da.size() && i < exp_da.size(); i++) begin
            chk_cnt++; if (obs_ca[i] !== exp_ca[i]) $display("FAIL r0_cycle[%0d] got %0d want %0d", i, obs_ca[i], exp_ca[i]); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int seg = 0; seg < 4; seg++) begin
            int s;
            s = $urandom_range(0, 40);
            for (int i = 0; i < 300; i++)
                drive($urandom_range(0, 9) < 7, int'($urandom_range(0, 4095)) - 2048, $urandom_range(0, 127), s);
            for (int i = 0; i < 12; i++) drive(0, 0, 0, s);
        end
        chk_cnt++; if (obs_da.size() !== exp_da.size()) $display("FAIL rnd_count_a got %0d want %0d", obs_da.size(), exp_da.size()); else pass_cnt++;
        chk_cnt++; if (obs_db.size() !== exp_db.size()) $display("FAIL rnd_count_b got %0d want %0d", obs_db.size(), exp_db.size()); else pass_cnt++;
        for (int i = 0; i < obs_da.size() && i < exp_da.size(); i++) begin
            chk_cnt++; if (obs_da[i] !== exp_da[i] || obs_ca[i] !== exp_ca[i])
                $display("FAIL rnd_a[%0d] got %0d@%0d want %0d@%0d", i, obs_da[i], obs_ca[i], exp_da[i], exp_ca[i]); else pass_cnt++;
        end
        for (int i = 0; i < obs_db.size() && i < exp_db.size(); i++) begin
            chk_cnt++; if (obs_db[i] !== exp_db[i] || obs_cb[i] !== exp_cb[i])
                $display("FAIL rnd_b[%0d] got %0d@%0d want %0d@%0d", i, obs_db[i], obs_cb[i], exp_db[i], exp_cb[i]); else pass_cnt++;
        end
    endtask

    task automatic test_reset_midrun();
        int e_rel;
        do_reset();
        for (int i = 0; i < 14; i++) drive(1, 1, 4, 0);
        #2 arst = 1'b1;
        #1;
        chk_cnt++; if (ifa.out_valid !== 1'b0) $display("FAIL mid_reset_valid got %0b want 0", ifa.out_valid); else pass_cnt++;
        chk_cnt++; if (ifa.data_out !== 16'sd0) $display("FAIL mid_reset_data got %0d want 0", ifa.data_out); else pass_cnt++;
        model_clear();
        @(negedge clk);
        arst = 1'b0;
        e_rel = cyc;
        for (int i = 0; i < 20; i++) drive(1, 1, 4, 0);
        for (int i = 0; i < 10; i++) drive(0, 0, 4, 0);
        if (obs_ca.size() > 0) begin
            chk_cnt++; if (obs_ca[0] !== e_rel + 4 + SA + 2) $display("FAIL mid_first got %0d want %0d", obs_ca[0] - e_rel, 4 + SA + 2); else pass_cnt++;
        end else begin
            chk_cnt++; $display("FAIL mid_first got none want one output");
        end
        for (int i = 0; i < obs_da.size() && i < exp_da.size(); i++) begin
            chk_cnt++; if (obs_da[i] !== exp_da[i]) $display("FAIL mid_data[%0d] got %0d want %0d", i, obs_da[i], exp_da[i]); else pass_cnt++;
        end
    endtask

    initial begin
        ifa.in_valid = 1'b0; ifa.data_in = '0; ifa.dec_ratio = '0; ifa.shift = '0;
        ifb.in_valid = 1'b0; ifb.data_in = '0; ifb.dec_ratio = '0; ifb.shift = '0;
        @(negedge clk);
        do_reset();
        test_reset();
        test_dc();
        test_gaps();
        test_round();
        test_saturation();
        test_ratio_change();
        test_ratio_zero();
        test_random();
        test_reset_midrun();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
